pif_led_arbiter: RTL and testbench
==================================

Name: pif_led_arbiter

Overview:
- Shares the single red/green LED pair between three status requesters, ordered by priority.
- Grants one requester at a time and latches that requester's colour/pattern configuration.
- Runs the blink patterns from a prescaled beat counter and enforces a minimum display time, followed by a blank gap between messages.
- Sits in front of the LED pins and replaces free-running flashing once more than one source needs the LEDs.

Parameters:
- PRESCALE, 1200: xclk cycles per beat (≥2).
- PS_W, 11: prescaler width; must satisfy 2^PS_W ≥ PRESCALE.
- MIN_HOLD, 8: minimum beats a granted pattern is displayed (≥1).
- GAP_BEATS, 1: blank beats between consecutive grants (≥1).

Ports:
- xclk  input  1  system clock
- sys_rst  input  1  reset, synchronous to xclk, active-high
- req  input  3  level requests; req[0] highest priority, req[2] lowest
- cfg  input  12  per-requester config; cfg[4i+3:4i] = {mode[1:0], red_en, green_en}
- grant  output  3  one-hot registered grant; 000 when idle
- red  output  1  red LED drive, registered
- green  output  1  green LED drive, registered
- tick  output  1  one-cycle beat strobe, registered

Behaviour:
- Reset (sys_rst=1 at an edge): state=IDLE; grant=000; red=0; green=0; tick=0; prescaler=0; phase=0; hold/gap counters=0. Reset wins over every other event, including mid-SHOW and mid-GAP.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for the cycle after the prescaler reaches PRESCALE-1. phase (3-bit) increments on each tick, modulo 8.
- States:
  - IDLE: red=green=0. If req≠0, grant the highest-priority asserted bit, latch its cfg nibble, clear prescaler/phase/hold, go to SHOW.
  - SHOW: hold counts ticks. When the MIN_HOLD-th tick occurs, clear gap and go to GAP; grant stays asserted until that edge. The granted requester dropping req before hold expires does not shorten the display.
  - GAP: red=green=0; grant=000. When the GAP_BEATS-th tick occurs: if req≠0, grant as in IDLE and go to SHOW; else go to IDLE.
  - Preemption: req[0]=1 while in GAP, or in SHOW with grant≠001, grants requester 0 on the next edge. This latches cfg[3:0], clears counters, goes to SHOW and bypasses the hold and the gap.
- Pattern, evaluated from latched cfg and the current phase:
  - mode 00: solid; red=red_en, green=green_en.
  - mode 01: slow blink; enabled colours on while phase[2]=0.
  - mode 10: fast blink; enabled colours on while phase[0]=0.
  - mode 11: alternate; red=red_en & ~phase[0], green=green_en & phase[0].
- Latency:
  - req sampled at edge E → grant visible after E (state SHOW, phase=0).
  - red/green reflect the new grant one cycle later (registered from state).
  - tick is registered one cycle after the prescaler wrap, aligned with the phase update.
- Arithmetic: hold and gap counters are wide enough for MIN_HOLD and GAP_BEATS, and compare to value-1 on tick. Counter overflow is impossible by construction.
- Simultaneous events:
  - Expiry tick coinciding with req[0] assertion in SHOW with grant≠001: preemption takes precedence.
  - Expiry coinciding with grant=001: normal transition to GAP.
  - cfg changes while granted are ignored until the next grant.
- grant is always one-hot or zero.
- Lower-priority requests are re-evaluated only in IDLE and at gap end; no starvation guarantee is made.

Test Plan (PRESCALE=4, MIN_HOLD=2, GAP_BEATS=1):
- Reset: sys_rst=1 for 3 cycles with req=111 → grant=000, red=green=tick=0 throughout; first grant=001 on the edge after sys_rst drops.
- Single request: req=100, cfg[11:8]=0010 (solid red) → grant=100 one edge later; red=1 the following cycle. Red stays 1 for 8 cycles, then grant=000 and red=0 for 4 cycles, then IDLE if req dropped.
- Priority: req=110 from IDLE → grant=010. After hold plus gap with req held at 110, grant=010 again (no rotation); with req=100 at gap end, grant=100.
- Preemption: grant=100 mid-SHOW, assert req[0] with cfg[3:0]=0001 → grant=001 on the next edge and green=1 one cycle later, with no gap inserted.
- Patterns: grant requester with cfg nibble 1111 (alternate) and MIN_HOLD=8 → red/green toggle complementarily every tick, starting red=1 at phase 0.
- Mid-operation reset: pulse sys_rst for 1 cycle during GAP → all outputs 0 on that edge, state IDLE; a pending req is granted on the following edge.

Source files
------------

// File: rtl/pif_led_arbiter.sv
// pif_led_arbiter
//   Shares one red/green LED pair between three status requesters. The
//   highest-priority active request is granted, its colour/pattern nibble is
//   latched, and the pattern runs for at least MIN_HOLD beats, followed by
//   GAP_BEATS blank beats. Requester 0 may preempt any other display or a gap.
//
// Ports
//   xclk     in   system clock
//   sys_rst  in   synchronous active-high reset
//   req[2:0] in   level requests, bit 0 highest priority
//   cfg[11:0]in   per-requester nibble {mode[1:0], red_en, green_en}
//   grant    out  one-hot registered grant, 000 when nothing is shown
//   red      out  registered red LED drive
//   green    out  registered green LED drive
//   tick     out  registered one-cycle beat strobe
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | LEDs dark, waiting for any request
// SHOW  | granted pattern on the LEDs, hold counter running
// GAP   | LEDs dark between messages, gap counter running
module pif_led_arbiter #(
    parameter int PRESCALE  = 1200,
    parameter int PS_W      = 11,
    parameter int MIN_HOLD  = 8,
    parameter int GAP_BEATS = 1
) (
    input  logic        xclk,
    input  logic        sys_rst,
    input  logic [2:0]  req,
    input  logic [11:0] cfg,
    output logic [2:0]  grant,
    output logic        red,
    output logic        green,
    output logic        tick
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int GAP_W  = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PS_W-1:0]     r_ps;
    logic [2:0]          r_phase;
    logic [HOLD_W-1:0]   r_hold;
    logic [GAP_W-1:0]    r_gap;
    logic [3:0]          r_cfg;
    logic [2:0]          r_grant;
    logic                r_red;
    logic                r_green;
    logic                r_tick;

    logic                w_wrap;
    logic                w_hold_done;
    logic                w_gap_done;
    logic                w_preempt;
    logic                w_start;
    logic [2:0]          w_pick;
    logic [3:0]          w_pick_cfg;
    logic                w_pat_red;
    logic                w_pat_green;

    assign w_wrap      = (r_ps == PS_W'(PRESCALE - 1));
    assign w_hold_done = (r_hold == HOLD_W'(MIN_HOLD - 1));
    assign w_gap_done  = (r_gap == GAP_W'(GAP_BEATS - 1));

    always_comb begin
        w_pick     = 3'b000;
        w_pick_cfg = 4'b0000;
        if (req[0]) begin
            w_pick     = 3'b001;
            w_pick_cfg = cfg[3:0];
        end else if (req[1]) begin
            w_pick     = 3'b010;
            w_pick_cfg = cfg[7:4];
        end else if (req[2]) begin
            w_pick     = 3'b100;
            w_pick_cfg = cfg[11:8];
        end
    end

    // Requester 0 cuts into a lower-priority display or skips the gap.
    assign w_preempt = req[0] &&
                       (((r_state == ST_SHOW) && (r_grant != 3'b001)) ||
                        (r_state == ST_GAP));

    // Every new grant (from IDLE, preemption, or gap end) picks the
    // highest-priority request, so one start path covers all three.
    assign w_start = ((r_state == ST_IDLE) && (req != 3'b000)) ||
                     w_preempt ||
                     ((r_state == ST_GAP) && w_wrap && w_gap_done &&
                      (req != 3'b000));

    always_comb begin
        w_pat_red   = 1'b0;
        w_pat_green = 1'b0;
        case (r_cfg[3:2])
            2'b00: begin
                w_pat_red   = r_cfg[1];
                w_pat_green = r_cfg[0];
            end
            2'b01: begin
                w_pat_red   = r_cfg[1] & ~r_phase[2];
                w_pat_green = r_cfg[0] & ~r_phase[2];
            end
            2'b10: begin
                w_pat_red   = r_cfg[1] & ~r_phase[0];
                w_pat_green = r_cfg[0] & ~r_phase[0];
            end
            default: begin
                w_pat_red   = r_cfg[1] & ~r_phase[0];
                w_pat_green = r_cfg[0] &  r_phase[0];
            end
        endcase
    end

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_ps    <= '0;
            r_phase <= 3'd0;
            r_hold  <= '0;
            r_gap   <= '0;
            r_cfg   <= 4'b0000;
            r_grant <= 3'b000;
            r_red   <= 1'b0;
            r_green <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_ps    <= '0;
                r_tick  <= 1'b1;
                r_phase <= r_phase + 3'd1;
            end else begin
                r_ps    <= r_ps + PS_W'(1);
                r_tick  <= 1'b0;
            end

            r_red   <= (r_state == ST_SHOW) & w_pat_red;
            r_green <= (r_state == ST_SHOW) & w_pat_green;

            if (w_start) begin
                r_state <= ST_SHOW;
                r_grant <= w_pick;
                r_cfg   <= w_pick_cfg;
                r_ps    <= '0;
                r_phase <= 3'd0;
                r_hold  <= '0;
                r_gap   <= '0;
            end else if (w_wrap) begin
                case (r_state)
                    ST_SHOW: begin
                        if (w_hold_done) begin
                            r_state <= ST_GAP;
                            r_grant <= 3'b000;
                            r_gap   <= '0;
                        end else begin
                            r_hold <= r_hold + HOLD_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_done) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign grant = r_grant;
    assign red   = r_red;
    assign green = r_green;
    assign tick  = r_tick;

endmodule

// File: tb/tb_pif_led_arbiter.sv
module tb_pif_led_arbiter;

    localparam int PRESCALE  = 4;
    localparam int PS_W      = 2;
    localparam int MIN_HOLD  = 2;
    localparam int GAP_BEATS = 1;

    localparam int M_IDLE = 0;
    localparam int M_SHOW = 1;
    localparam int M_GAP  = 2;

    logic        xclk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [11:0] cfg = 12'h000;
    logic [2:0]  grant;
    logic        red;
    logic        green;
    logic        tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats counted since the current grant/gap began.
    int       m_mode  = M_IDLE;
    int       m_ps    = 0;
    int       m_beats = 0;
    bit [2:0] m_grant = 3'b000;
    bit [3:0] m_nib   = 4'b0000;
    bit       e_red   = 1'b0;
    bit       e_green = 1'b0;
    bit       e_tick  = 1'b0;

    always #5 xclk = ~xclk;

    pif_led_arbiter #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W),
        .MIN_HOLD (MIN_HOLD),
        .GAP_BEATS(GAP_BEATS)
    ) dut (
        .xclk   (xclk),
        .sys_rst(sys_rst),
        .req    (req),
        .cfg    (cfg),
        .grant  (grant),
        .red    (red),
        .green  (green),
        .tick   (tick)
    );

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s at %0t: got=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    // Phase during a display is simply the beat count modulo 8.
    task automatic pattern(input bit [3:0] nib, input int beats, output bit r_on, output bit g_on);
        int ph;
        ph = beats % 8;
        r_on = 1'b0;
        g_on = 1'b0;
        case (nib[3:2])
            2'd0: begin r_on = nib[1]; g_on = nib[0]; end
            2'd1: begin r_on = nib[1] && (ph < 4); g_on = nib[0] && (ph < 4); end
            2'd2: begin r_on = nib[1] && (ph % 2 == 0); g_on = nib[0] && (ph % 2 == 0); end
            default: begin r_on = nib[1] && (ph % 2 == 0); g_on = nib[0] && (ph % 2 == 1); end
        endcase
    endtask

    task automatic model_edge(input bit rst, input bit [2:0] q, input bit [11:0] c);
        bit wrap, pre, go, r_on, g_on;
        int nb, idx;
        if (rst) begin
            m_mode = M_IDLE; m_grant = 3'b000; m_ps = 0; m_beats = 0; m_nib = 4'b0000;
            e_red = 1'b0; e_green = 1'b0; e_tick = 1'b0;
            return;
        end
        wrap   = (m_ps == PRESCALE - 1);
        e_tick = wrap;
        pattern(m_nib, m_beats, r_on, g_on);
        e_red   = (m_mode == M_SHOW) && r_on;
        e_green = (m_mode == M_SHOW) && g_on;
        m_ps = wrap ? 0 : m_ps + 1;
        nb   = m_beats + (wrap ? 1 : 0);
        pre  = q[0] && ((m_mode == M_SHOW && m_grant != 3'b001) || m_mode == M_GAP);
        go   = (m_mode == M_IDLE && q != 3'b000) || pre ||
               (m_mode == M_GAP && nb == GAP_BEATS && q != 3'b000);
        if (go) begin
            idx     = q[0] ? 0 : (q[1] ? 1 : 2);
            m_grant = 3'(1 << idx);
            m_nib   = c[4*idx +: 4];
            m_mode  = M_SHOW;
            m_beats = 0;
            m_ps    = 0;
        end else if (m_mode == M_SHOW && nb == MIN_HOLD) begin
            m_mode = M_GAP; m_grant = 3'b000; m_beats = 0;
        end else if (m_mode == M_GAP && nb == GAP_BEATS) begin
            m_mode = M_IDLE; m_beats = 0;
        end else if (m_mode != M_IDLE) begin
            m_beats = nb;
        end
    endtask

    task automatic cycle(input bit r, input bit [2:0] q, input bit [11:0] c);
        sys_rst = r;
        req     = q;
        cfg     = c;
        @(posedge xclk);
        model_edge(r, q, c);
        @(negedge xclk);
        chk("grant", grant, m_grant);
        chk("red", {2'b00, red}, {2'b00, e_red});
        chk("green", {2'b00, green}, {2'b00, e_green});
        chk("tick", {2'b00, tick}, {2'b00, e_tick});
    endtask

    task automatic go_idle();
        int n;
        n = 0;
        while (m_mode != M_IDLE && n < 40) begin
            cycle(1'b0, 3'b000, 12'h000);
            n++;
        end
        chk("idle_reached", {2'b00, (m_mode == M_IDLE)}, 3'b001);
    endtask

    initial begin
        bit [2:0]  q;
        bit [11:0] c;
        int n;

        // Reset held with all requests pending.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'b111, 12'h000);
            chk("rst_grant", grant, 3'b000);
            chk("rst_leds", {1'b0, red, green}, 3'b000);
        end
        cycle(1'b0, 3'b111, 12'h000);
        chk("first_grant", grant, 3'b001);
        go_idle();

        // Single request, solid red.
        cycle(1'b0, 3'b100, 12'h200);
        chk("single_grant", grant, 3'b100);
        cycle(1'b0, 3'b100, 12'h200);
        chk("single_red", {2'b00, red}, 3'b001);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'b000, 12'h200);
        go_idle();

        // Priority: no rotation while req stays 110, then 100 at gap end.
        cycle(1'b0, 3'b110, 12'h000);
        chk("prio_grant", grant, 3'b010);
        for (int i = 0; i < 12; i++) cycle(1'b0, 3'b110, 12'h000);
        chk("prio_regrant", grant, 3'b010);
        for (int i = 0; i < 12; i++) cycle(1'b0, 3'b100, 12'h000);
        chk("prio_low", grant, 3'b100);
        go_idle();

        // Preemption of requester 2 mid-display by requester 0 (green).
        cycle(1'b0, 3'b100, 12'h201);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b100, 12'h201);
        cycle(1'b0, 3'b101, 12'h201);
        chk("preempt_grant", grant, 3'b001);
        cycle(1'b0, 3'b001, 12'h201);
        chk("preempt_green", {2'b00, green}, 3'b001);
        go_idle();

        // Alternate pattern on requester 1.
        cycle(1'b0, 3'b010, 12'h0F0);
        cycle(1'b0, 3'b010, 12'h0F0);
        chk("alt_first", {1'b0, red, green}, 3'b010);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'b010, 12'h0F0);
        chk("alt_second", {1'b0, red, green}, 3'b001);

        // Reset pulse during the gap, pending request granted right after.
        n = 0;
        while (m_mode != M_GAP && n < 40) begin
            cycle(1'b0, 3'b010, 12'h0F0);
            n++;
        end
        chk("gap_reached", {2'b00, (m_mode == M_GAP)}, 3'b001);
        cycle(1'b1, 3'b010, 12'h0F0);
        chk("midrst_out", {grant[2:1], grant[0] | red | green | tick}, 3'b000);
        cycle(1'b0, 3'b010, 12'h0F0);
        chk("midrst_regrant", grant, 3'b010);
        go_idle();

        // Randomized traffic against the model.
        q = 3'b000;
        c = 12'h000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) q = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) c = 12'($urandom);
            cycle(($urandom_range(0, 299) == 0), q, c);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
